// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load unit.
// FSM encoding, access sizes, lane offsets and decode helpers.
package dmem_pkg;

  localparam int RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } size_e;

  // Big-endian byte lanes: offset 0 is the MSB.
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;

  // Byte wins when both size flags are set.
  function automatic size_e dec_size(
    input logic is_byte,
    input logic is_half
  );
    if (is_byte)
      return SZ_BYTE;
    else if (is_half)
      return SZ_HALF;
    else
      return SZ_WORD;
  endfunction

  function automatic logic is_misal(
    input size_e      sz,
    input logic [1:0] off
  );
    return ((sz == SZ_HALF) && off[0]) ||
           ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_load_unit_if.sv
// Request, DMem read bus and response signals of the load unit.
// slave = load unit side, master = requester/memory side.
interface dmem_load_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        Do_Byte;
  logic        Do_Half;
  logic        Do_Unsigned;
  logic [31:0] Address_in;
  logic [31:0] dmem_addr;
  logic        dmem_rd_en;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        busy;

  modport slave (
    input  req_valid,
    input  Do_Byte,
    input  Do_Half,
    input  Do_Unsigned,
    input  Address_in,
    input  dmem_rdata,
    output req_ready,
    output dmem_addr,
    output dmem_rd_en,
    output load_data,
    output load_valid,
    output misalign,
    output busy
  );

  modport master (
    output req_valid,
    output Do_Byte,
    output Do_Half,
    output Do_Unsigned,
    output Address_in,
    output dmem_rdata,
    input  req_ready,
    input  dmem_addr,
    input  dmem_rd_en,
    input  load_data,
    input  load_valid,
    input  misalign,
    input  busy
  );

endinterface

// File: rtl/dmem_load_unit_load_extract.sv
// Lane selection and sign/zero extension of a loaded word.
// Purely combinational; big-endian lane order.
module load_extract
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        uns_i,
  output logic [31:0] res_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane and extend it to 32 bits.
  always_comb begin
    byte_s = word_i[7:0];
    unique case (off_i)
      OFF_B0: byte_s = word_i[31:24];
      OFF_B1: byte_s = word_i[23:16];
      OFF_B2: byte_s = word_i[15:8];
      OFF_B3: byte_s = word_i[7:0];
    endcase
    half_s = off_i[1] ? word_i[15:0] : word_i[31:16];
    res_o  = word_i;
    unique case (size_i)
      SZ_BYTE: res_o = {{24{~uns_i & byte_s[7]}}, byte_s};
      SZ_HALF: res_o = {{16{~uns_i & half_s[15]}}, half_s};
      default: res_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_load_unit.sv
// Load unit: accepts a load, issues one DMem read, waits RD_LAT,
// extracts the lane and returns a one-cycle result or misalign pulse.
module dmem_load_unit
  import dmem_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  dmem_load_unit_if.slave bus
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  off_q;
  size_e       size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        mis_q;

  size_e       req_size;
  logic        req_mis;
  logic        accept;
  logic        capture;
  logic [31:0] ext_data;

  assign req_size = dec_size(bus.Do_Byte, bus.Do_Half);
  assign req_mis  = is_misal(req_size, bus.Address_in[1:0]);
  assign accept   = bus.req_valid && (state_q == S_IDLE);
  assign capture  = (state_q == S_WAIT) && (cnt_q == 2'd0);

  load_extract u_extract (
    .word_i (bus.dmem_rdata),
    .off_i  (off_q),
    .size_i (size_q),
    .uns_i  (uns_q),
    .res_o  (ext_data)
  );

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !req_mis)
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0)
          state_d = S_RESP;
        else
          cnt_d = cnt_q - 2'd1;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture, misalign pulse and result register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      off_q  <= 2'd0;
      size_q <= SZ_WORD;
      uns_q  <= 1'b0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      mis_q  <= 1'b0;
    end else begin
      mis_q <= accept && req_mis;
      if (accept && !req_mis) begin
        off_q  <= bus.Address_in[1:0];
        size_q <= req_size;
        uns_q  <= bus.Do_Unsigned;
        addr_q <= {bus.Address_in[31:2], 2'b00};
      end
      if (accept && req_mis)
        data_q <= 32'd0;
      else if (capture)
        data_q <= ext_data;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.dmem_rd_en = (state_q == S_ISSUE);
  assign bus.dmem_addr  = addr_q;
  assign bus.load_valid = (state_q == S_RESP);
  assign bus.misalign   = mis_q;
  assign bus.load_data  = data_q;

endmodule

// File: tb/tb_dmem_load_unit.sv
// Directed bench for dmem_load_unit at RD_LAT=1 and RD_LAT=3.
// Each instance gets a small delayed-read memory model.
module tb_dmem_load_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  logic [31:0] word_a = 32'd0;
  logic [31:0] word_b = 32'd0;
  logic [0:0]  sha;
  logic [2:0]  shb;

  dmem_load_unit_if a_if ();
  dmem_load_unit_if b_if ();

  dmem_load_unit #(.RD_LAT(1)) u_a (
    .clock (clk),
    .reset (rst),
    .bus   (a_if)
  );

  dmem_load_unit #(.RD_LAT(3)) u_b (
    .clock (clk),
    .reset (rst),
    .bus   (b_if)
  );

  always #5 clk = ~clk;

  // Memory returns the word RD_LAT cycles after the strobe, junk otherwise.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sha <= '0;
      shb <= '0;
    end else begin
      sha <= a_if.dmem_rd_en;
      shb <= {shb[1:0], b_if.dmem_rd_en};
    end
  end

  assign a_if.dmem_rdata = sha[0] ? word_a : 32'hBAD0BAD0;
  assign b_if.dmem_rdata = shb[2] ? word_b : 32'hBAD0BAD0;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input string tag, input logic b, input logic h,
                        input logic u, input logic [31:0] ad,
                        input logic [31:0] w, input logic [31:0] exp);
    logic [31:0] wa;
    wa = {ad[31:2], 2'b00};
    @(negedge clk);
    word_a           = w;
    a_if.Do_Byte     = b;
    a_if.Do_Half     = h;
    a_if.Do_Unsigned = u;
    a_if.Address_in  = ad;
    a_if.req_valid   = 1'b1;
    chk({tag, ".rdy0"}, a_if.req_ready, 1);
    @(negedge clk);
    a_if.req_valid = 1'b0;
    chk({tag, ".rden"}, a_if.dmem_rd_en, 1);
    chk({tag, ".addr"}, a_if.dmem_addr, wa);
    chk({tag, ".busy"}, a_if.busy, 1);
    chk({tag, ".rdy1"}, a_if.req_ready, 0);
    @(negedge clk);
    chk({tag, ".rden2"}, a_if.dmem_rd_en, 0);
    chk({tag, ".lv2"}, a_if.load_valid, 0);
    @(negedge clk);
    chk({tag, ".lv3"}, a_if.load_valid, 1);
    chk({tag, ".data"}, a_if.load_data, exp);
    chk({tag, ".mis3"}, a_if.misalign, 0);
    @(negedge clk);
    chk({tag, ".lv4"}, a_if.load_valid, 0);
    chk({tag, ".hold"}, a_if.load_data, exp);
    chk({tag, ".rdy4"}, a_if.req_ready, 1);
  endtask

  task automatic misal_a(input string tag, input logic h,
                         input logic [31:0] ad);
    @(negedge clk);
    a_if.Do_Byte     = 1'b0;
    a_if.Do_Half     = h;
    a_if.Do_Unsigned = 1'b0;
    a_if.Address_in  = ad;
    a_if.req_valid   = 1'b1;
    chk({tag, ".rdy0"}, a_if.req_ready, 1);
    @(negedge clk);
    a_if.req_valid = 1'b0;
    chk({tag, ".mis"}, a_if.misalign, 1);
    chk({tag, ".data"}, a_if.load_data, 0);
    chk({tag, ".rden"}, a_if.dmem_rd_en, 0);
    chk({tag, ".rdy1"}, a_if.req_ready, 1);
    chk({tag, ".lv1"}, a_if.load_valid, 0);
    @(negedge clk);
    chk({tag, ".mis2"}, a_if.misalign, 0);
    chk({tag, ".rden2"}, a_if.dmem_rd_en, 0);
    chk({tag, ".busy2"}, a_if.busy, 0);
  endtask

  initial begin
    a_if.req_valid   = 1'b0;
    a_if.Do_Byte     = 1'b0;
    a_if.Do_Half     = 1'b0;
    a_if.Do_Unsigned = 1'b0;
    a_if.Address_in  = 32'd0;
    b_if.req_valid   = 1'b0;
    b_if.Do_Byte     = 1'b0;
    b_if.Do_Half     = 1'b0;
    b_if.Do_Unsigned = 1'b0;
    b_if.Address_in  = 32'd0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.rdy", a_if.req_ready, 1);
    chk("rst.busy", a_if.busy, 0);
    chk("rst.rden", a_if.dmem_rd_en, 0);
    chk("rst.addr", a_if.dmem_addr, 0);
    chk("rst.data", a_if.load_data, 0);
    chk("rst.lv", a_if.load_valid, 0);
    chk("rst.mis", a_if.misalign, 0);
    chk("rst.b.rdy", b_if.req_ready, 1);

    load_a("lb",   1, 0, 0, 32'h11, 32'h12F45678, 32'hFFFFFFF4);
    load_a("lbu",  1, 0, 1, 32'h11, 32'h12F45678, 32'h000000F4);
    load_a("lhu",  0, 1, 1, 32'h02, 32'h1234ABCD, 32'h0000ABCD);
    load_a("lh",   0, 1, 0, 32'h02, 32'h1234ABCD, 32'hFFFFABCD);

    misal_a("mis.lw6", 0, 32'h6);
    misal_a("mis.lh3", 1, 32'h3);

    load_a("lh0",  0, 1, 0, 32'h40, 32'h87651234, 32'hFFFF8765);
    load_a("lb0",  1, 0, 0, 32'h20, 32'h7F000000, 32'h0000007F);
    load_a("bh",   1, 1, 0, 32'h02, 32'h1234ABCD, 32'hFFFFFFAB);
    load_a("lwu",  0, 0, 1, 32'h04, 32'h80000001, 32'h80000001);
    load_a("lb3",  1, 0, 0, 32'h103, 32'h00000080, 32'hFFFFFF80);

    @(negedge clk);
    word_b           = 32'hDEADBEEF;
    b_if.Address_in  = 32'h8;
    b_if.req_valid   = 1'b1;
    chk("b.rdy0", b_if.req_ready, 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        b_if.Address_in  = 32'hB;
        b_if.Do_Byte     = 1'b1;
        b_if.Do_Unsigned = 1'b1;
        chk("b.addr", b_if.dmem_addr, 32'h8);
      end
      chk($sformatf("b.rden%0d", k), b_if.dmem_rd_en, (k == 1));
      chk($sformatf("b.lv%0d", k), b_if.load_valid, (k == 5));
      chk($sformatf("b.rdy%0d", k), b_if.req_ready, (k == 6));
      chk($sformatf("b.busy%0d", k), b_if.busy, (k != 6));
      if (k == 5)
        chk("b.data", b_if.load_data, 32'hDEADBEEF);
    end
    @(negedge clk);
    b_if.req_valid = 1'b0;
    chk("b2.rden", b_if.dmem_rd_en, 1);
    chk("b2.addr", b_if.dmem_addr, 32'h8);
    chk("b2.hold", b_if.load_data, 32'hDEADBEEF);
    for (int k = 8; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("b2.lv%0d", k), b_if.load_valid, (k == 11));
      if (k == 11)
        chk("b2.data", b_if.load_data, 32'h000000EF);
    end

    @(negedge clk);
    word_a           = 32'hCAFEF00D;
    a_if.Do_Byte     = 1'b0;
    a_if.Do_Half     = 1'b0;
    a_if.Do_Unsigned = 1'b0;
    a_if.Address_in  = 32'h10;
    a_if.req_valid   = 1'b1;
    @(negedge clk);
    a_if.req_valid = 1'b0;
    chk("mr.rden", a_if.dmem_rd_en, 1);
    @(negedge clk);
    chk("mr.busy", a_if.busy, 1);
    rst = 1'b1;
    #1;
    chk("mr.rden0", a_if.dmem_rd_en, 0);
    chk("mr.addr0", a_if.dmem_addr, 0);
    chk("mr.data0", a_if.load_data, 0);
    chk("mr.lv0", a_if.load_valid, 0);
    chk("mr.mis0", a_if.misalign, 0);
    chk("mr.busy0", a_if.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mr.lv%0d", k), a_if.load_valid, 0);
      chk($sformatf("mr.rdy%0d", k), a_if.req_ready, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
